// File: rtl/idct_1d.sv
// Streaming 8-point 1-D inverse DCT: one coefficient in and one sample out per enabled cycle,
// with ping-pong coefficient and result banks giving a fixed 16-enabled-cycle latency.
module idct_1d #(
    parameter int W_IN  = 12,
    parameter int W_OUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena_in,
    input  logic signed [W_IN-1:0]  S_in,
    output logic signed [W_OUT-1:0] x_out,
    output logic                    valid_out
);

    localparam int W_C    = 13;
    localparam int FRAC   = 12;
    localparam int W_PROD = W_IN + W_C;
    localparam int W_ACC  = W_PROD + 3;
    localparam logic signed [W_ACC-1:0] ROUND  = W_ACC'(2 ** (FRAC - 1));
    localparam logic signed [W_ACC-1:0] SAT_HI = W_ACC'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [W_ACC-1:0] SAT_LO = W_ACC'(-(2 ** (W_OUT - 1)));

    // round(2048 * cos(m*pi/16)) for m = 0..8
    function automatic logic signed [W_C-1:0] cos_mag(input int m);
        case (m)
            0:       cos_mag = 13'sd2048;
            1:       cos_mag = 13'sd2009;
            2:       cos_mag = 13'sd1892;
            3:       cos_mag = 13'sd1703;
            4:       cos_mag = 13'sd1448;
            5:       cos_mag = 13'sd1138;
            6:       cos_mag = 13'sd784;
            7:       cos_mag = 13'sd400;
            default: cos_mag = 13'sd0;
        endcase
    endfunction

    // Q1.12 basis weight (C(k)/2)*cos((2n+1)*k*pi/16), folded onto the first quadrant
    function automatic logic signed [W_C-1:0] coef(input logic [2:0] n, input logic [2:0] k);
        int m;
        m = ((2 * int'(n) + 1) * int'(k)) % 32;
        if (k == 3'd0)    coef = 13'sd1448;
        else if (m <= 8)  coef = cos_mag(m);
        else if (m <= 16) coef = -cos_mag(16 - m);
        else if (m <= 24) coef = -cos_mag(m - 16);
        else              coef = cos_mag(32 - m);
    endfunction

    logic        [2:0]       phase_q, phase_d;
    logic                    bank_q, bank_d;
    logic        [4:0]       warm_q, warm_d;
    logic                    valid_q, valid_d;
    logic signed [W_OUT-1:0] x_out_q, x_out_d;
    logic signed [W_IN-1:0]  in_buf_q  [2][8];
    logic signed [W_IN-1:0]  in_buf_d  [2][8];
    logic signed [W_OUT-1:0] out_buf_q [2][8];
    logic signed [W_OUT-1:0] out_buf_d [2][8];

    logic signed [W_PROD-1:0] prod;
    logic signed [W_ACC-1:0]  acc;
    logic signed [W_ACC-1:0]  acc_rnd;
    logic signed [W_OUT-1:0]  sample;
    logic                     rd_bank;
    logic        [2:0]        rd_idx;

    // x[phase] of the previous block, computed from the bank that finished filling last
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int k = 0; k < 8; k++) begin
            prod = W_PROD'(in_buf_q[~bank_q][k]) * W_PROD'(coef(phase_q, 3'(k)));
            acc  = acc + W_ACC'(prod);
        end
        acc_rnd = (acc + ROUND) >>> FRAC;
        if (acc_rnd > SAT_HI)      sample = SAT_HI[W_OUT-1:0];
        else if (acc_rnd < SAT_LO) sample = SAT_LO[W_OUT-1:0];
        else                       sample = acc_rnd[W_OUT-1:0];
    end

    // Readout leads the compute phase by one: at phase 7 x[0] of the block just being
    // computed is read from the current bank, otherwise entries come from the other bank.
    assign rd_idx  = phase_q + 3'd1;
    assign rd_bank = (phase_q == 3'd7) ? bank_q : ~bank_q;

    always_comb begin
        phase_d   = phase_q;
        bank_d    = bank_q;
        warm_d    = warm_q;
        valid_d   = valid_q;
        x_out_d   = x_out_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        if (ena_in) begin
            phase_d                     = phase_q + 3'd1;
            bank_d                      = (phase_q == 3'd7) ? ~bank_q : bank_q;
            in_buf_d[bank_q][phase_q]   = S_in;
            out_buf_d[bank_q][phase_q]  = sample;
            if (warm_q != 5'd16) warm_d = warm_q + 5'd1;
            valid_d                     = (warm_q >= 5'd15);
            x_out_d                     = valid_d ? out_buf_q[rd_bank][rd_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            bank_q  <= 1'b0;
            warm_q  <= '0;
            valid_q <= 1'b0;
            x_out_q <= '0;
        end else begin
            phase_q <= phase_d;
            bank_q  <= bank_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
            x_out_q <= x_out_d;
        end
    end

    // Bank contents are don't-care after reset: the warm-up window overwrites them.
    always_ff @(posedge clk) begin
        in_buf_q  <= in_buf_d;
        out_buf_q <= out_buf_d;
    end

    assign x_out     = x_out_q;
    assign valid_out = valid_q;

endmodule

// File: doc/idct_1d.md
IDCT_1D -- requirements
Module: idct_1d

Interface
REQ-001 The module SHALL have parameter W_IN, default 12: signed DCT coefficient input width.
REQ-002 The module SHALL have parameter W_OUT, default 8: signed reconstructed sample output width.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port ena_in, input, 1 bit: pipeline advance enable; 1 = accept one coefficient and advance, 0 = freeze.
REQ-006 The module SHALL have port S_in, input, W_IN bits: signed two's-complement coefficient X[k], natural order k=0..7.
REQ-007 The module SHALL have port x_out, output, W_OUT bits: signed two's-complement sample x[n], natural order n=0..7.
REQ-008 The module SHALL have port valid_out, output, 1 bit: x_out carries a reconstructed sample.

Function
REQ-009 The module SHALL keep a 3-bit phase counter: 0 on reset, +1 on each ena_in=1 cycle, wrapping 7->0; S_in at phase p is X[p] of the current block.
REQ-010 The module SHALL compute x[n] = sum over k=0..7 of (C(k)/2)*X[k]*cos((2n+1)*k*pi/16), with C(0)=1/sqrt(2) and C(k)=1 for k>0.
REQ-011 The module SHALL use 13-bit signed Q1.12 constants, each equal to round(value*4096).
REQ-012 The module SHALL size internal adders and multipliers so that no intermediate overflows for any W_IN input.
REQ-013 The module SHALL round the final result half-up (add 0.5 LSB, then floor) and saturate it to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
REQ-014 Each unsaturated x[n] SHALL be within +/-1 LSB of the double-precision model; DC-only blocks SHALL be exact.
REQ-015 The module SHALL buffer input coefficients in an 8-entry ping-pong buffer: one bank fills while the other is consumed.
REQ-016 The module SHALL drive results through an 8-entry ping-pong output buffer, giving full throughput of one sample per enabled cycle with back-to-back blocks and no bubbles.
REQ-017 Latency: if X[0] of block j is accepted on enabled cycle e, x_out SHALL present x[0] of block j during enabled cycle e+16 and x[n] during enabled cycle e+16+n.
REQ-018 The output phase SHALL equal the input phase: x[p] of block j-2 is on x_out while X[p] of block j is on S_in.
REQ-019 When ena_in=0, the module SHALL hold all state (phase, buffers, pipeline registers, x_out, valid_out), and outputs SHALL be unchanged.
REQ-020 The module SHALL keep a warm-up counter of enabled cycles since reset; valid_out SHALL be 0 until 16 enabled cycles have completed, then 1 until the next reset.
REQ-021 x_out SHALL be 0 whenever valid_out=0; stale buffer contents SHALL never appear on x_out.
REQ-022 ena_in=1 in the same cycle as rst=1 SHALL be ignored (reset dominates).

Reset
REQ-023 When rst=1 at a clock edge, the module SHALL set phase=0, warm-up count=0, valid_out=0 and x_out=0.
REQ-024 Buffer and datapath contents need not be cleared on reset.
REQ-025 Reset mid-block SHALL discard all partial and in-flight blocks; the next enabled cycle after reset SHALL be phase 0 of a new block.

Verification
REQ-026 The bench SHALL cover the DC case: X=[64,0,0,0,0,0,0,0], continuous ena_in -> x[0..7]=23 each, first at enabled cycle 16, valid_out rising at that cycle.
REQ-027 The bench SHALL cover the single AC case: X[1]=100, others 0 -> x=[49,42,28,10,-10,-28,-42,-49], +/-1 tolerance.
REQ-028 The bench SHALL cover saturation: X[0]=2047 (model 723.7) -> x[0..7]=127; X[0]=-2048 -> x[0..7]=-128.
REQ-029 The bench SHALL cover a stall: ena_in=0 for 3 cycles at input phase 4 of block 1 -> x_out and valid_out frozen during the stall, sample sequence identical to the no-stall run.
REQ-030 The bench SHALL cover reset mid-block: rst at phase 5 of block 2 -> next cycle valid_out=0 and x_out=0, 16 further enabled cycles with valid_out=0, then the new block's samples correct.
REQ-031 The bench SHALL cover random soak: 10,000 back-to-back blocks of random W_IN-bit coefficients with random ena_in gaps -> every sample within +/-1 LSB of the model, zero bubbles while ena_in=1.
